// File: rtl/clint_arb_pkg.sv
// clint_arb_pkg
//   Shared types and helpers for the CLINT request arbiter.
//   - arb_state_e : arbiter FSM states (IDLE, ISSUE, RESP)
//   - tl_a_req_t  : TileLink-UL A-channel beat at the default CLINT widths
//   - tl_d_rsp_t  : TileLink-UL D-channel beat at the default CLINT widths
//   - wrap_inc    : modulo-n increment used for the round-robin pointer
package clint_arb_pkg;

  localparam int CLINT_SRC_W  = 11;
  localparam int CLINT_ADDR_W = 26;
  localparam int CLINT_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [2:0]                  opcode;
    logic [2:0]                  param;
    logic [1:0]                  size;
    logic [CLINT_SRC_W-1:0]      source;
    logic [CLINT_ADDR_W-1:0]     address;
    logic [CLINT_DATA_W/8-1:0]   mask;
    logic [CLINT_DATA_W-1:0]     data;
    logic                        corrupt;
  } tl_a_req_t;

  typedef struct packed {
    logic [2:0]                  opcode;
    logic [1:0]                  size;
    logic [CLINT_SRC_W-1:0]      source;
    logic [CLINT_DATA_W-1:0]     data;
  } tl_d_rsp_t;

  // Increment with explicit wrap at n-1, so non-power-of-2 counts work.
  function automatic logic [31:0] wrap_inc(input logic [31:0] v, input int unsigned n);
    return (v >= n - 1) ? 32'd0 : v + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter. The search starts at requester
//   `ptr` and moves upward, wrapping to 0.
//   Ports:
//     req     [N_REQ]  request vector
//     ptr     [IDX_W]  first requester to consider
//     gnt     [N_REQ]  one-hot grant (all zero when nothing requests)
//     gnt_idx [IDX_W]  binary index of the granted requester
//     any     [1]      at least one request present
module rr_arbiter
  import clint_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  localparam int W2 = 2 * N_REQ;

  // The request vector is laid out twice. Bits below ptr are masked off in
  // the lower copy, so the lowest set bit of the result is the first
  // requester at or above ptr. If there is none, the search falls through
  // to the unmasked upper copy, which gives the wrap-around.
  logic [W2-1:0] dbl_masked;

  genvar gi;
  generate
    for (gi = 0; gi < W2; gi++) begin : g_mask
      if (gi < N_REQ) begin : g_lo
        assign dbl_masked[gi] = req[gi] & (32'(gi) >= 32'(ptr));
      end else begin : g_hi
        assign dbl_masked[gi] = req[gi-N_REQ];
      end
    end
  endgenerate

  logic found;
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int j = 0; j < W2; j++) begin
      if (!found && dbl_masked[j]) begin
        found   = 1'b1;
        gnt_idx = (j >= N_REQ) ? IDX_W'(j - N_REQ) : IDX_W'(j);
      end
    end
  end

  assign any = |req;

  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_gnt
      assign gnt[gi] = any & (gnt_idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/clint_req_arbiter.sv
// clint_req_arbiter
//   Shares the single TileLink-UL slave port of the CLINT between N_REQ
//   requesters. Only one transaction is outstanding at a time. The winning
//   A beat is registered before it is issued, and the same-cycle D beat
//   from the CLINT is registered before it is returned. This cuts the
//   CLINT's combinational A->D path.
//   Ports:
//     clock, reset          clock; asynchronous active-low reset
//     in_a_*  [N_REQ slices] requester A channels (in_a_ready is one-hot)
//     in_d_*                 one-hot in_d_valid per requester, shared fields
//     out_a_*                registered A channel toward the CLINT
//     out_d_*                D channel from the CLINT (out_d_ready registered)
//     busy                   FSM not in IDLE
module clint_req_arbiter
  import clint_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int SRC_W  = CLINT_SRC_W,
  parameter int ADDR_W = CLINT_ADDR_W,
  parameter int DATA_W = CLINT_DATA_W
) (
  input  logic                      clock,
  input  logic                      reset,
  // requester side
  input  logic [N_REQ-1:0]          in_a_valid,
  output logic [N_REQ-1:0]          in_a_ready,
  input  logic [3*N_REQ-1:0]        in_a_opcode,
  input  logic [3*N_REQ-1:0]        in_a_param,
  input  logic [2*N_REQ-1:0]        in_a_size,
  input  logic [SRC_W*N_REQ-1:0]    in_a_source,
  input  logic [ADDR_W*N_REQ-1:0]   in_a_address,
  input  logic [(DATA_W/8)*N_REQ-1:0] in_a_mask,
  input  logic [DATA_W*N_REQ-1:0]   in_a_data,
  input  logic [N_REQ-1:0]          in_a_corrupt,
  output logic [N_REQ-1:0]          in_d_valid,
  input  logic [N_REQ-1:0]          in_d_ready,
  output logic [2:0]                in_d_opcode,
  output logic [1:0]                in_d_size,
  output logic [SRC_W-1:0]          in_d_source,
  output logic [DATA_W-1:0]         in_d_data,
  // CLINT side
  output logic                      out_a_valid,
  input  logic                      out_a_ready,
  output logic [2:0]                out_a_opcode,
  output logic [2:0]                out_a_param,
  output logic [1:0]                out_a_size,
  output logic [SRC_W-1:0]          out_a_source,
  output logic [ADDR_W-1:0]         out_a_address,
  output logic [DATA_W/8-1:0]       out_a_mask,
  output logic [DATA_W-1:0]         out_a_data,
  output logic                      out_a_corrupt,
  input  logic                      out_d_valid,
  output logic                      out_d_ready,
  input  logic [2:0]                out_d_opcode,
  input  logic [1:0]                out_d_size,
  input  logic [SRC_W-1:0]          out_d_source,
  input  logic [DATA_W-1:0]         out_d_data,
  output logic                      busy
);

  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int MASK_W = DATA_W / 8;

  // Unpacked per-requester views of the flat input vectors.
  logic [2:0]        req_opcode  [N_REQ];
  logic [2:0]        req_param   [N_REQ];
  logic [1:0]        req_size    [N_REQ];
  logic [SRC_W-1:0]  req_source  [N_REQ];
  logic [ADDR_W-1:0] req_address [N_REQ];
  logic [MASK_W-1:0] req_mask    [N_REQ];
  logic [DATA_W-1:0] req_data    [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_opcode[gi]  = in_a_opcode[gi*3 +: 3];
      assign req_param[gi]   = in_a_param[gi*3 +: 3];
      assign req_size[gi]    = in_a_size[gi*2 +: 2];
      assign req_source[gi]  = in_a_source[gi*SRC_W +: SRC_W];
      assign req_address[gi] = in_a_address[gi*ADDR_W +: ADDR_W];
      assign req_mask[gi]    = in_a_mask[gi*MASK_W +: MASK_W];
      assign req_data[gi]    = in_a_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  arb_state_e        state_reg;
  logic [IDX_W-1:0]  rr_reg;
  logic [IDX_W-1:0]  win_idx_reg;

  logic              out_a_valid_reg;
  logic              out_d_ready_reg;
  logic              busy_reg;
  logic [N_REQ-1:0]  in_d_valid_reg;

  logic [2:0]        req_opcode_reg;
  logic [2:0]        req_param_reg;
  logic [1:0]        req_size_reg;
  logic [SRC_W-1:0]  req_source_reg;
  logic [ADDR_W-1:0] req_address_reg;
  logic [MASK_W-1:0] req_mask_reg;
  logic [DATA_W-1:0] req_data_reg;
  logic              req_corrupt_reg;

  logic [2:0]        rsp_opcode_reg;
  logic [1:0]        rsp_size_reg;
  logic [SRC_W-1:0]  rsp_source_reg;
  logic [DATA_W-1:0] rsp_data_reg;

  logic [N_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_any;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req     (in_a_valid),
    .ptr     (rr_reg),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  logic [N_REQ-1:0] win_onehot;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_win
      assign win_onehot[gi] = (win_idx_reg == IDX_W'(gi));
    end
  endgenerate

  // Accept is combinational from the arbiter. It is gated by reset so that
  // a requester holding valid through reset is never told it was accepted.
  assign in_a_ready = (state_reg == IDLE && reset) ? arb_gnt : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      rr_reg          <= '0;
      win_idx_reg     <= '0;
      out_a_valid_reg <= 1'b0;
      out_d_ready_reg <= 1'b0;
      busy_reg        <= 1'b0;
      in_d_valid_reg  <= '0;
      req_opcode_reg  <= '0;
      req_param_reg   <= '0;
      req_size_reg    <= '0;
      req_source_reg  <= '0;
      req_address_reg <= '0;
      req_mask_reg    <= '0;
      req_data_reg    <= '0;
      req_corrupt_reg <= 1'b0;
      rsp_opcode_reg  <= '0;
      rsp_size_reg    <= '0;
      rsp_source_reg  <= '0;
      rsp_data_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (arb_any) begin
            req_opcode_reg  <= req_opcode[arb_idx];
            req_param_reg   <= req_param[arb_idx];
            req_size_reg    <= req_size[arb_idx];
            req_source_reg  <= req_source[arb_idx];
            req_address_reg <= req_address[arb_idx];
            req_mask_reg    <= req_mask[arb_idx];
            req_data_reg    <= req_data[arb_idx];
            req_corrupt_reg <= in_a_corrupt[arb_idx];
            win_idx_reg     <= arb_idx;
            out_a_valid_reg <= 1'b1;
            out_d_ready_reg <= 1'b1;
            busy_reg        <= 1'b1;
            state_reg       <= ISSUE;
          end
        end
        ISSUE: begin
          // The CLINT answers in the same cycle it accepts. Ready without a
          // response is not expected, so the FSM just keeps waiting.
          if (out_a_valid_reg && out_a_ready && out_d_valid) begin
            rsp_opcode_reg  <= out_d_opcode;
            rsp_size_reg    <= out_d_size;
            rsp_source_reg  <= out_d_source;
            rsp_data_reg    <= out_d_data;
            out_a_valid_reg <= 1'b0;
            out_d_ready_reg <= 1'b0;
            in_d_valid_reg  <= win_onehot;
            state_reg       <= RESP;
          end
        end
        RESP: begin
          if (|(in_d_ready & in_d_valid_reg)) begin
            in_d_valid_reg <= '0;
            rr_reg         <= IDX_W'(wrap_inc(32'(win_idx_reg), N_REQ));
            busy_reg       <= 1'b0;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign out_a_valid   = out_a_valid_reg;
  assign out_a_opcode  = req_opcode_reg;
  assign out_a_param   = req_param_reg;
  assign out_a_size    = req_size_reg;
  assign out_a_source  = req_source_reg;
  assign out_a_address = req_address_reg;
  assign out_a_mask    = req_mask_reg;
  assign out_a_data    = req_data_reg;
  assign out_a_corrupt = req_corrupt_reg;
  assign out_d_ready   = out_d_ready_reg;

  assign in_d_valid    = in_d_valid_reg;
  assign in_d_opcode   = rsp_opcode_reg;
  assign in_d_size     = rsp_size_reg;
  assign in_d_source   = rsp_source_reg;
  assign in_d_data     = rsp_data_reg;

  assign busy          = busy_reg;

endmodule

// File: tb/tb_clint_req_arbiter.sv
module tb_clint_req_arbiter;

  logic clock;
  logic reset;

  // ---------------- 4-requester DUT ----------------
  logic [3:0]   in_a_valid, in_a_ready;
  logic [11:0]  in_a_opcode, in_a_param;
  logic [7:0]   in_a_size;
  logic [43:0]  in_a_source;
  logic [103:0] in_a_address;
  logic [31:0]  in_a_mask;
  logic [255:0] in_a_data;
  logic [3:0]   in_a_corrupt;
  logic [3:0]   in_d_valid, in_d_ready;
  logic [2:0]   in_d_opcode;
  logic [1:0]   in_d_size;
  logic [10:0]  in_d_source;
  logic [63:0]  in_d_data;
  logic         out_a_valid, out_a_ready;
  logic [2:0]   out_a_opcode, out_a_param;
  logic [1:0]   out_a_size;
  logic [10:0]  out_a_source;
  logic [25:0]  out_a_address;
  logic [7:0]   out_a_mask;
  logic [63:0]  out_a_data;
  logic         out_a_corrupt;
  logic         out_d_valid, out_d_ready;
  logic [2:0]   out_d_opcode;
  logic [1:0]   out_d_size;
  logic [10:0]  out_d_source;
  logic [63:0]  out_d_data;
  logic         busy;
  logic         clint_stall;

  clint_req_arbiter dut (
    .clock(clock), .reset(reset),
    .in_a_valid(in_a_valid), .in_a_ready(in_a_ready),
    .in_a_opcode(in_a_opcode), .in_a_param(in_a_param), .in_a_size(in_a_size),
    .in_a_source(in_a_source), .in_a_address(in_a_address), .in_a_mask(in_a_mask),
    .in_a_data(in_a_data), .in_a_corrupt(in_a_corrupt),
    .in_d_valid(in_d_valid), .in_d_ready(in_d_ready),
    .in_d_opcode(in_d_opcode), .in_d_size(in_d_size),
    .in_d_source(in_d_source), .in_d_data(in_d_data),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
    .out_a_opcode(out_a_opcode), .out_a_param(out_a_param), .out_a_size(out_a_size),
    .out_a_source(out_a_source), .out_a_address(out_a_address), .out_a_mask(out_a_mask),
    .out_a_data(out_a_data), .out_a_corrupt(out_a_corrupt),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready),
    .out_d_opcode(out_d_opcode), .out_d_size(out_d_size),
    .out_d_source(out_d_source), .out_d_data(out_d_data),
    .busy(busy)
  );

  // CLINT model: a_ready follows d_ready, d_valid follows a_valid.
  // Gets (opcode 4) return AccessAckData with address-derived data.
  assign out_a_ready  = out_d_ready & ~clint_stall;
  assign out_d_valid  = out_a_valid;
  assign out_d_opcode = (out_a_opcode == 3'd4) ? 3'd1 : 3'd0;
  assign out_d_size   = out_a_size;
  assign out_d_source = out_a_source;
  assign out_d_data   = (out_a_opcode == 3'd4) ? (64'hC0DE_0000_0000_0000 | {38'h0, out_a_address}) : 64'h0;

  // ---------------- 3-requester DUT ----------------
  logic [2:0]   c3_a_valid, c3_a_ready;
  logic [8:0]   c3_a_opcode, c3_a_param;
  logic [5:0]   c3_a_size;
  logic [32:0]  c3_a_source;
  logic [77:0]  c3_a_address;
  logic [23:0]  c3_a_mask;
  logic [191:0] c3_a_data;
  logic [2:0]   c3_a_corrupt;
  logic [2:0]   c3_d_valid, c3_d_ready;
  logic [2:0]   c3_d_opcode;
  logic [1:0]   c3_d_size;
  logic [10:0]  c3_d_source;
  logic [63:0]  c3_d_data;
  logic         c3_oa_valid, c3_oa_ready;
  logic [2:0]   c3_oa_opcode, c3_oa_param;
  logic [1:0]   c3_oa_size;
  logic [10:0]  c3_oa_source;
  logic [25:0]  c3_oa_address;
  logic [7:0]   c3_oa_mask;
  logic [63:0]  c3_oa_data;
  logic         c3_oa_corrupt;
  logic         c3_od_valid, c3_od_ready;
  logic         c3_busy;

  clint_req_arbiter #(.N_REQ(3)) dut3 (
    .clock(clock), .reset(reset),
    .in_a_valid(c3_a_valid), .in_a_ready(c3_a_ready),
    .in_a_opcode(c3_a_opcode), .in_a_param(c3_a_param), .in_a_size(c3_a_size),
    .in_a_source(c3_a_source), .in_a_address(c3_a_address), .in_a_mask(c3_a_mask),
    .in_a_data(c3_a_data), .in_a_corrupt(c3_a_corrupt),
    .in_d_valid(c3_d_valid), .in_d_ready(c3_d_ready),
    .in_d_opcode(c3_d_opcode), .in_d_size(c3_d_size),
    .in_d_source(c3_d_source), .in_d_data(c3_d_data),
    .out_a_valid(c3_oa_valid), .out_a_ready(c3_oa_ready),
    .out_a_opcode(c3_oa_opcode), .out_a_param(c3_oa_param), .out_a_size(c3_oa_size),
    .out_a_source(c3_oa_source), .out_a_address(c3_oa_address), .out_a_mask(c3_oa_mask),
    .out_a_data(c3_oa_data), .out_a_corrupt(c3_oa_corrupt),
    .out_d_valid(c3_od_valid), .out_d_ready(c3_od_ready),
    .out_d_opcode(c3_oa_opcode), .out_d_size(c3_oa_size),
    .out_d_source(c3_oa_source), .out_d_data(c3_oa_data),
    .busy(c3_busy)
  );

  assign c3_oa_ready = c3_od_ready;
  assign c3_od_valid = c3_oa_valid;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          idx;
    logic [2:0]  op;
    logic [10:0] src;
    logic [63:0] data;
  } exp_t;

  exp_t        exp_rsp[$];
  int          exp_gnt[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_rsp    = 0;
  logic [3:0]  oneshot;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [10:0] src,
                         input logic [25:0] addr, input logic [63:0] data);
    in_a_opcode[i*3 +: 3]    = op;
    in_a_param[i*3 +: 3]     = 3'd0;
    in_a_size[i*2 +: 2]      = 2'd3;
    in_a_source[i*11 +: 11]  = src;
    in_a_address[i*26 +: 26] = addr;
    in_a_mask[i*8 +: 8]      = 8'hFF;
    in_a_data[i*64 +: 64]    = data;
    in_a_corrupt[i]          = 1'b0;
  endtask

  task automatic push_exp(input int i, input logic [2:0] op, input logic [10:0] src,
                          input logic [25:0] addr);
    exp_t e;
    exp_gnt.push_back(i);
    e.idx  = i;
    e.op   = (op == 3'd4) ? 3'd1 : 3'd0;
    e.src  = src;
    e.data = (op == 3'd4) ? (64'hC0DE_0000_0000_0000 | {38'h0, addr}) : 64'h0;
    exp_rsp.push_back(e);
  endtask

  task automatic pop_check_rsp();
    exp_t e;
    if (exp_rsp.size() == 0) begin
      chk("rsp_unexpected", 64'(in_d_valid), 64'h0);
    end else begin
      e = exp_rsp.pop_front();
      chk("rsp_route",  64'(in_d_valid),  64'(1) << e.idx);
      chk("rsp_opcode", 64'(in_d_opcode), 64'(e.op));
      chk("rsp_source", 64'(in_d_source), 64'(e.src));
      chk("rsp_data",   in_d_data,        e.data);
      $display("txn req=%0d opcode=%0d source=%h data=%h", e.idx, in_d_opcode, in_d_source, in_d_data);
    end
    n_rsp++;
  endtask

  // One clock: sample at the falling edge, then advance past the rising edge.
  task automatic step(output bit got);
    logic [3:0] acc;
    int g;
    got = 1'b0;
    @(negedge clock);
    acc = in_a_ready & in_a_valid;
    if (in_a_ready != 4'b0) begin
      if (exp_gnt.size() == 0) chk("gnt_unexpected", 64'(in_a_ready), 64'h0);
      else begin
        g = exp_gnt.pop_front();
        chk("gnt_order", 64'(in_a_ready), 64'(1) << g);
      end
    end
    if (out_a_valid && out_a_ready) chk("clint_d_with_a", 64'(out_d_valid), 64'h1);
    if ((in_d_valid & in_d_ready) != 4'b0) begin
      pop_check_rsp();
      got = 1'b1;
    end
    @(posedge clock);
    #1;
    in_a_valid = in_a_valid & ~(acc & oneshot);
  endtask

  task automatic run_until(input int target, input int budget);
    int cyc = 0;
    bit got;
    while (n_rsp < target && cyc < budget) begin
      step(got);
      cyc++;
    end
    chk("rsp_count", 64'(n_rsp), 64'(target));
  endtask

  initial begin
    bit got;
    logic [63:0] hold;
    reset        = 1'b0;
    clint_stall  = 1'b0;
    oneshot      = 4'b1111;
    in_a_valid   = 4'b0001;
    in_a_opcode  = '0; in_a_param = '0; in_a_size = '0; in_a_source = '0;
    in_a_address = '0; in_a_mask  = '0; in_a_data = '0; in_a_corrupt = '0;
    in_d_ready   = 4'b1111;
    c3_a_valid   = '0; c3_a_opcode = {3{3'd4}}; c3_a_param = '0; c3_a_size = '0;
    c3_a_source  = {11'h32, 11'h31, 11'h30}; c3_a_address = '0; c3_a_mask = '0;
    c3_a_data    = '0; c3_a_corrupt = '0; c3_d_ready = 3'b111;

    // Reset state, with a requester already holding valid.
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_in_a_ready",  64'(in_a_ready),  64'h0);
    chk("rst_in_d_valid",  64'(in_d_valid),  64'h0);
    chk("rst_out_a_valid", 64'(out_a_valid), 64'h0);
    chk("rst_out_d_ready", 64'(out_d_ready), 64'h0);
    chk("rst_busy",        64'(busy),        64'h0);
    in_a_valid = 4'b0000;
    @(posedge clock); #1;
    reset = 1'b1;

    // All four requesters read continuously: strict rotation 0..3 twice.
    oneshot = 4'b0000;
    for (int i = 0; i < 4; i++) set_req(i, 3'd4, 11'h10 + 11'(i), 26'h0BFF8 + 26'(8 * i), 64'h0);
    for (int k = 0; k < 8; k++) push_exp(k % 4, 3'd4, 11'h10 + 11'(k % 4), 26'h0BFF8 + 26'(8 * (k % 4)));
    in_a_valid = 4'b1111;
    run_until(8, 60);
    in_a_valid = 4'b0000;
    oneshot    = 4'b1111;

    // Single write from requester 2, latency checked cycle by cycle.
    set_req(2, 3'd0, 11'h222, 26'h4000, 64'h1234);
    push_exp(2, 3'd0, 11'h222, 26'h4000);
    in_a_valid[2] = 1'b1;
    step(got);                                   // cycle 0: grant
    chk("c0_gnt_empty", 64'(exp_gnt.size()), 64'h0);
    @(negedge clock);                            // cycle 1: issue
    chk("c1_out_a_valid", 64'(out_a_valid),   64'h1);
    chk("c1_out_a_data",  out_a_data,         64'h1234);
    chk("c1_out_a_mask",  64'(out_a_mask),    64'hFF);
    chk("c1_out_a_addr",  64'(out_a_address), 64'h4000);
    chk("c1_busy",        64'(busy),          64'h1);
    chk("c1_in_d_valid",  64'(in_d_valid),    64'h0);
    @(posedge clock); #1;
    step(got);                                   // cycle 2: response
    chk("c2_rsp_seen", 64'(got), 64'h1);
    @(negedge clock);                            // cycle 3: idle again
    chk("c3_busy",       64'(busy),       64'h0);
    chk("c3_in_d_valid", 64'(in_d_valid), 64'h0);
    @(posedge clock); #1;

    // Pointer now 3: requesters 0 and 3 together -> 3 first, then 0.
    set_req(0, 3'd4, 11'h100, 26'h0000, 64'h0);
    set_req(3, 3'd4, 11'h103, 26'h0008, 64'h0);
    push_exp(3, 3'd4, 11'h103, 26'h0008);
    push_exp(0, 3'd4, 11'h100, 26'h0000);
    in_a_valid = 4'b1001;
    run_until(n_rsp + 2, 20);

    // Requester 1 read with its d_ready held low for 5 cycles.
    in_d_ready = 4'b1101;
    set_req(1, 3'd4, 11'h101, 26'h0BFF8, 64'h0);
    push_exp(1, 3'd4, 11'h101, 26'h0BFF8);
    in_a_valid[1] = 1'b1;
    step(got);
    set_req(0, 3'd4, 11'h180, 26'h0010, 64'h0);
    push_exp(0, 3'd4, 11'h180, 26'h0010);
    in_a_valid[0] = 1'b1;
    @(posedge clock); #1;
    hold = 64'hC0DE_0000_0000_0000 | 64'h0BFF8;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("stall_d_valid",  64'(in_d_valid), 64'h2);
      chk("stall_d_data",   in_d_data,       hold);
      chk("stall_no_grant", 64'(in_a_ready), 64'h0);
      @(posedge clock); #1;
    end
    in_d_ready = 4'b1111;
    run_until(n_rsp + 2, 20);

    // CLINT holds out_a_ready low for 3 cycles during ISSUE.
    clint_stall = 1'b1;
    set_req(3, 3'd0, 11'h333, 26'h4018, 64'hDEAD_BEEF_0000_0003);
    push_exp(3, 3'd0, 11'h333, 26'h4018);
    in_a_valid[3] = 1'b1;
    step(got);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("bp_out_a_valid", 64'(out_a_valid),   64'h1);
      chk("bp_out_a_data",  out_a_data,         64'hDEAD_BEEF_0000_0003);
      chk("bp_out_a_addr",  64'(out_a_address), 64'h4018);
      chk("bp_out_a_src",   64'(out_a_source),  64'h333);
      chk("bp_busy",        64'(busy),          64'h1);
      chk("bp_in_d_valid",  64'(in_d_valid),    64'h0);
      @(posedge clock); #1;
    end
    clint_stall = 1'b0;
    run_until(n_rsp + 1, 10);

    // Move the pointer to 2, then abort a requester-2 read in RESP by reset.
    set_req(1, 3'd4, 11'h111, 26'h0020, 64'h0);
    push_exp(1, 3'd4, 11'h111, 26'h0020);
    in_a_valid[1] = 1'b1;
    run_until(n_rsp + 1, 10);
    in_d_ready = 4'b0000;
    set_req(2, 3'd4, 11'h222, 26'h0028, 64'h0);
    push_exp(2, 3'd4, 11'h222, 26'h0028);
    in_a_valid[2] = 1'b1;
    step(got);
    @(posedge clock); #1;
    @(negedge clock);
    chk("pre_rst_d_valid", 64'(in_d_valid), 64'h4);
    for (int i = 0; i < 4; i++) set_req(i, 3'd4, 11'h40 + 11'(i), 26'h0100 + 26'(8 * i), 64'h0);
    in_a_valid = 4'b1111;
    #2 reset = 1'b0;
    #1;
    chk("arst_in_a_ready",  64'(in_a_ready),  64'h0);
    chk("arst_in_d_valid",  64'(in_d_valid),  64'h0);
    chk("arst_out_a_valid", 64'(out_a_valid), 64'h0);
    chk("arst_out_d_ready", 64'(out_d_ready), 64'h0);
    chk("arst_busy",        64'(busy),        64'h0);
    exp_rsp.delete();
    exp_gnt.delete();
    in_d_ready = 4'b1111;
    for (int i = 0; i < 4; i++) push_exp(i, 3'd4, 11'h40 + 11'(i), 26'h0100 + 26'(8 * i));
    @(posedge clock); #1;
    reset = 1'b1;
    run_until(n_rsp + 4, 30);

    // Three requesters: grant 2, pointer wraps to 0, then 0 beats 1.
    c3_a_valid = 3'b100;
    @(negedge clock);
    chk("n3_gnt2", 64'(c3_a_ready), 64'h4);
    @(posedge clock); #1;
    c3_a_valid = 3'b000;
    @(negedge clock);
    chk("n3_issue", 64'(c3_oa_source), 64'h32);
    @(posedge clock); #1;
    @(negedge clock);
    chk("n3_d_valid", 64'(c3_d_valid), 64'h4);
    @(posedge clock); #1;
    c3_a_valid = 3'b011;
    @(negedge clock);
    chk("n3_wrap_gnt0", 64'(c3_a_ready), 64'h1);
    @(posedge clock); #1;
    c3_a_valid = 3'b000;
    repeat (4) @(posedge clock);
    @(negedge clock);
    chk("n3_idle", 64'(c3_busy), 64'h0);

    chk("sb_rsp_empty", 64'(exp_rsp.size()), 64'h0);
    chk("sb_gnt_empty", 64'(exp_gnt.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
